// File: rtl/ccd_frame_packer.sv
// Collects one CCD line of 12-bit samples into a small FIFO and emits it as a framed
// byte stream (header, frame count, 3-bytes-per-2-pixels payload, status, checksum).
module ccd_frame_packer #(
    parameter int PIXELS     = 5340,
    parameter int FIFO_DEPTH = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        frame_start,
    input  logic        pix_valid,
    input  logic [11:0] pix_data,
    input  logic        pix_of,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready,
    output logic        busy,
    output logic        overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = AW + 1;
    localparam int NW = $clog2(PIXELS + 1);
    localparam logic [NW-1:0] PIX_N   = NW'(PIXELS);
    localparam logic [CW-1:0] DEPTH_N = CW'(FIFO_DEPTH);

    localparam logic [3:0] S_IDLE = 4'd0;
    localparam logic [3:0] S_HDR0 = 4'd1;
    localparam logic [3:0] S_HDR1 = 4'd2;
    localparam logic [3:0] S_FCNT = 4'd3;
    localparam logic [3:0] S_PAY0 = 4'd4;
    localparam logic [3:0] S_PAY1 = 4'd5;
    localparam logic [3:0] S_PAY2 = 4'd6;
    localparam logic [3:0] S_STAT = 4'd7;
    localparam logic [3:0] S_CSUM = 4'd8;

    logic [3:0]    state_q, state_d;
    logic [7:0]    out_data_q, out_data_d;
    logic          out_valid_q, out_valid_d;
    logic [7:0]    fcnt_q, fcnt_d;
    logic [7:0]    csum_q, csum_d;
    logic [NW-1:0] in_cnt_q, in_cnt_d;
    logic [NW-1:0] out_cnt_q, out_cnt_d;
    logic          win_q, win_d;
    logic          ovf_frame_q, ovf_frame_d;
    logic          of_frame_q, of_frame_d;
    logic          overflow_q, overflow_d;
    logic [11:0]   p0_q, p0_d;
    logic [11:0]   p1_q, p1_d;
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;

    logic [11:0]   fifo_mem [FIFO_DEPTH];
    logic          xfer, push, drop, pay_ready;
    logic [CW-1:0] pop_n;
    logic [11:0]   pop_p0, pop_p1;
    logic [7:0]    stat_byte, pay0_byte;

    // Two entries may leave in one cycle, so the FIFO is read asynchronously.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= pix_data;
        end
    end

    always_comb begin
        xfer      = out_valid_q & out_ready;
        push      = win_q & pix_valid & (count_q != DEPTH_N);
        drop      = win_q & pix_valid & (count_q == DEPTH_N);
        stat_byte = {ovf_frame_q, of_frame_q, 6'b0};
        pay_ready = (state_q == S_PAY0) && !out_valid_q && ((count_q >= CW'(2)) || !win_q);

        pop_n  = '0;
        pop_p0 = 12'h000;
        pop_p1 = 12'h000;
        if (count_q >= CW'(2)) begin
            pop_n  = CW'(2);
            pop_p0 = fifo_mem[rd_ptr_q];
            pop_p1 = fifo_mem[rd_ptr_q + AW'(1)];
        end else if (count_q == CW'(1)) begin
            pop_n  = CW'(1);
            pop_p0 = fifo_mem[rd_ptr_q];
        end
        pay0_byte = pop_p0[11:4];

        state_d     = state_q;
        out_data_d  = out_data_q;
        out_valid_d = out_valid_q;
        fcnt_d      = fcnt_q;
        csum_d      = csum_q;
        in_cnt_d    = in_cnt_q;
        out_cnt_d   = out_cnt_q;
        win_d       = win_q;
        ovf_frame_d = ovf_frame_q;
        of_frame_d  = of_frame_q;
        overflow_d  = overflow_q;
        p0_d        = p0_q;
        p1_d        = p1_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;

        if (win_q && pix_valid) begin
            in_cnt_d = in_cnt_q + NW'(1);
            if (in_cnt_q + NW'(1) == PIX_N) begin
                win_d = 1'b0;
            end
            if (pix_of) begin
                of_frame_d = 1'b1;
            end
            if (drop) begin
                ovf_frame_d = 1'b1;
                overflow_d  = 1'b1;
            end
        end

        if (push) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (pay_ready) begin
            rd_ptr_d = rd_ptr_q + AW'(pop_n);
        end
        count_d = count_q + CW'(push) - (pay_ready ? pop_n : CW'(0));

        case (state_q)
            S_IDLE: begin
                if (frame_start) begin
                    state_d     = S_HDR0;
                    out_data_d  = 8'hA5;
                    out_valid_d = 1'b1;
                    win_d       = 1'b1;
                    in_cnt_d    = '0;
                    out_cnt_d   = '0;
                    ovf_frame_d = 1'b0;
                    of_frame_d  = 1'b0;
                    csum_d      = 8'h00;
                    wr_ptr_d    = '0;
                    rd_ptr_d    = '0;
                    count_d     = '0;
                end
            end
            S_HDR0: if (xfer) begin
                state_d    = S_HDR1;
                out_data_d = 8'h5A;
            end
            S_HDR1: if (xfer) begin
                state_d    = S_FCNT;
                out_data_d = fcnt_q;
                csum_d     = fcnt_q;
            end
            S_FCNT: if (xfer) begin
                state_d     = S_PAY0;
                out_valid_d = 1'b0;
            end
            S_PAY0: begin
                // Missing pixels are padded with zero only once the window has closed.
                if (pay_ready) begin
                    p0_d        = pop_p0;
                    p1_d        = pop_p1;
                    out_data_d  = pay0_byte;
                    out_valid_d = 1'b1;
                    csum_d      = csum_q ^ pay0_byte;
                    out_cnt_d   = out_cnt_q + NW'(2);
                end else if (xfer) begin
                    state_d    = S_PAY1;
                    out_data_d = p1_q[11:4];
                    csum_d     = csum_q ^ p1_q[11:4];
                end
            end
            S_PAY1: if (xfer) begin
                state_d    = S_PAY2;
                out_data_d = {p0_q[3:0], p1_q[3:0]};
                csum_d     = csum_q ^ {p0_q[3:0], p1_q[3:0]};
            end
            S_PAY2: if (xfer) begin
                if (out_cnt_q == PIX_N) begin
                    state_d    = S_STAT;
                    out_data_d = stat_byte;
                    csum_d     = csum_q ^ stat_byte;
                end else begin
                    state_d     = S_PAY0;
                    out_valid_d = 1'b0;
                end
            end
            S_STAT: if (xfer) begin
                state_d    = S_CSUM;
                out_data_d = csum_q;
            end
            S_CSUM: if (xfer) begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                out_data_d  = 8'h00;
                fcnt_d      = fcnt_q + 8'd1;
            end
            default: begin
                state_d     = S_IDLE;
                out_valid_d = 1'b0;
                out_data_d  = 8'h00;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            out_data_q  <= 8'h00;
            out_valid_q <= 1'b0;
            fcnt_q      <= 8'h00;
            csum_q      <= 8'h00;
            in_cnt_q    <= '0;
            out_cnt_q   <= '0;
            win_q       <= 1'b0;
            ovf_frame_q <= 1'b0;
            of_frame_q  <= 1'b0;
            overflow_q  <= 1'b0;
            p0_q        <= 12'h000;
            p1_q        <= 12'h000;
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            count_q     <= '0;
        end else begin
            state_q     <= state_d;
            out_data_q  <= out_data_d;
            out_valid_q <= out_valid_d;
            fcnt_q      <= fcnt_d;
            csum_q      <= csum_d;
            in_cnt_q    <= in_cnt_d;
            out_cnt_q   <= out_cnt_d;
            win_q       <= win_d;
            ovf_frame_q <= ovf_frame_d;
            of_frame_q  <= of_frame_d;
            overflow_q  <= overflow_d;
            p0_q        <= p0_d;
            p1_q        <= p1_d;
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            count_q     <= count_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_valid = out_valid_q;
    assign busy      = (state_q != S_IDLE);
    assign overflow  = overflow_q;

endmodule

// File: tb/tb_ccd_frame_packer.sv
// Directed bench for ccd_frame_packer: a packet-level model predicts every byte, a
// monitor compares each transfer, and literal packets pin the model.
module tb_ccd_frame_packer;
    localparam int PIX  = 4;
    localparam int NB   = 3 + 3 * PIX / 2 + 2;
    localparam int DEPA = 16;
    localparam int DEPB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        frame_start_a, pix_valid_a, pix_of_a, out_ready_a;
    logic [11:0] pix_data_a;
    logic [7:0]  out_data_a;
    logic        out_valid_a, busy_a, overflow_a;
    logic        frame_start_b, pix_valid_b, pix_of_b, out_ready_b;
    logic [11:0] pix_data_b;
    logic [7:0]  out_data_b;
    logic        out_valid_b, busy_b, overflow_b;

    ccd_frame_packer #(.PIXELS(PIX), .FIFO_DEPTH(DEPA)) dut_a (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start_a), .pix_valid(pix_valid_a),
        .pix_data(pix_data_a), .pix_of(pix_of_a), .out_data(out_data_a), .out_valid(out_valid_a),
        .out_ready(out_ready_a), .busy(busy_a), .overflow(overflow_a));

    ccd_frame_packer #(.PIXELS(PIX), .FIFO_DEPTH(DEPB)) dut_b (
        .clk(clk), .rst_n(rst_n), .frame_start(frame_start_b), .pix_valid(pix_valid_b),
        .pix_data(pix_data_b), .pix_of(pix_of_b), .out_data(out_data_b), .out_valid(out_valid_b),
        .out_ready(out_ready_b), .busy(busy_b), .overflow(overflow_b));

    int vectors = 0;
    int miscompares = 0;
    logic [7:0] exp_a[$], exp_b[$], got_a[$], got_b[$];
    logic [7:0] fcnt_a = 8'h00, fcnt_b = 8'h00;
    logic [11:0] px[PIX];
    bit          ofs[PIX];
    bit          rand_mode = 1'b0;
    bit          prev_stall_a = 1'b0, prev_stall_b = 1'b0;
    logic [7:0]  prev_data_a, prev_data_b;
    int          base;

    logic [7:0] lit_basic[NB] = '{8'hA5, 8'h5A, 8'h00, 8'h12, 8'h45, 8'h36, 8'h78, 8'hAB, 8'h9C, 8'h00, 8'h2E};
    logic [7:0] lit_ovf[NB]   = '{8'hA5, 8'h5A, 8'h00, 8'h11, 8'h22, 8'h12, 8'h00, 8'h00, 8'h00, 8'h80, 8'hA1};

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] expv);
        vectors++;
        if (got !== expv) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, expv);
        end
    endtask

    // Packet model: pixels kept are the first 'keep' received (valid when nothing is
    // popped during input), the rest of the line is zero; checksum over FCNT..STAT.
    function automatic void model_frame(input logic [7:0] fc, input int n_rx, input int keep,
                                        output logic [7:0] b[NB]);
        logic [11:0] kept[PIX];
        logic [7:0]  cs;
        bit          any_of;
        any_of = 1'b0;
        for (int i = 0; i < PIX; i++) begin
            kept[i] = (i < n_rx && i < keep) ? px[i] : 12'h000;
            if (i < n_rx && ofs[i]) any_of = 1'b1;
        end
        b[0] = 8'hA5;
        b[1] = 8'h5A;
        b[2] = fc;
        for (int g = 0; g < PIX / 2; g++) begin
            b[3 + 3 * g] = kept[2 * g][11:4];
            b[4 + 3 * g] = kept[2 * g + 1][11:4];
            b[5 + 3 * g] = {kept[2 * g][3:0], kept[2 * g + 1][3:0]};
        end
        b[NB - 2] = {(n_rx > keep), any_of, 6'b0};
        cs = 8'h00;
        for (int i = 2; i <= NB - 2; i++) cs = cs ^ b[i];
        b[NB - 1] = cs;
    endfunction

    task automatic expect_frame(input bit sel, input int n_rx);
        logic [7:0] b[NB];
        if (sel) begin
            model_frame(fcnt_b, n_rx, DEPB, b);
            fcnt_b = fcnt_b + 8'd1;
            for (int i = 0; i < NB; i++) exp_b.push_back(b[i]);
        end else begin
            model_frame(fcnt_a, n_rx, DEPA, b);
            fcnt_a = fcnt_a + 8'd1;
            for (int i = 0; i < NB; i++) exp_a.push_back(b[i]);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pulse_start(input bit sel);
        if (sel) frame_start_b = 1'b1; else frame_start_a = 1'b1;
        tick();
        frame_start_a = 1'b0;
        frame_start_b = 1'b0;
    endtask

    task automatic drive_pixel(input bit sel, input logic [11:0] d, input bit of);
        if (sel) begin
            pix_valid_b = 1'b1; pix_data_b = d; pix_of_b = of;
        end else begin
            pix_valid_a = 1'b1; pix_data_a = d; pix_of_a = of;
        end
        tick();
        pix_valid_a = 1'b0; pix_of_a = 1'b0;
        pix_valid_b = 1'b0; pix_of_b = 1'b0;
    endtask

    task automatic wait_done(input bit sel, input string tag);
        int n = 0;
        while (n < 3000 && (sel ? (busy_b || exp_b.size() != 0) : (busy_a || exp_a.size() != 0))) begin
            tick();
            n++;
        end
        check({"timeout_", tag}, 32'(n < 3000), 32'd1);
    endtask

    task automatic full_frame(input bit sel, input string tag);
        expect_frame(sel, PIX);
        pulse_start(sel);
        for (int i = 0; i < PIX; i++) drive_pixel(sel, px[i], ofs[i]);
        wait_done(sel, tag);
    endtask

    // Single compare process: every transfer against the model, plus hold-under-stall.
    always @(negedge clk) begin
        if (!rst_n) begin
            prev_stall_a = 1'b0;
            prev_stall_b = 1'b0;
        end else begin
            if (prev_stall_a) begin
                check("hold_data_a", out_data_a, prev_data_a);
                check("hold_valid_a", out_valid_a, 1'b1);
            end
            if (out_valid_a && out_ready_a) begin
                got_a.push_back(out_data_a);
                if (exp_a.size() == 0) check("unexpected_a", {24'b0, out_data_a}, 32'h100);
                else check("stream_a", out_data_a, exp_a.pop_front());
            end
            prev_stall_a = out_valid_a && !out_ready_a;
            prev_data_a  = out_data_a;
            if (prev_stall_b) check("hold_data_b", out_data_b, prev_data_b);
            if (out_valid_b && out_ready_b) begin
                got_b.push_back(out_data_b);
                if (exp_b.size() == 0) check("unexpected_b", {24'b0, out_data_b}, 32'h100);
                else check("stream_b", out_data_b, exp_b.pop_front());
            end
            prev_stall_b = out_valid_b && !out_ready_b;
            prev_data_b  = out_data_b;
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #2;
            if (rand_mode) out_ready_a = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        #800000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        frame_start_a = 0; pix_valid_a = 0; pix_of_a = 0; pix_data_a = 0; out_ready_a = 1;
        frame_start_b = 0; pix_valid_b = 0; pix_of_b = 0; pix_data_b = 0; out_ready_b = 0;
        for (int i = 0; i < PIX; i++) ofs[i] = 1'b0;
        repeat (3) tick();
        check("rst_valid", out_valid_a, 1'b0);
        check("rst_data", out_data_a, 8'h00);
        check("rst_busy", busy_a, 1'b0);
        check("rst_overflow", overflow_a, 1'b0);
        rst_n = 1'b1;
        tick();

        // Basic frame with first-byte latency
        px[0] = 12'h123; px[1] = 12'h456; px[2] = 12'h789; px[3] = 12'hABC;
        base = got_a.size();
        expect_frame(0, PIX);
        pulse_start(0);
        check("lat_valid", out_valid_a, 1'b1);
        check("lat_data", out_data_a, 8'hA5);
        check("lat_busy", busy_a, 1'b1);
        for (int i = 0; i < PIX; i++) drive_pixel(0, px[i], 1'b0);
        wait_done(0, "basic");
        check("basic_busy", busy_a, 1'b0);
        check("basic_overflow", overflow_a, 1'b0);
        for (int i = 0; i < NB; i++) check("basic_literal", got_a[base + i], lit_basic[i]);

        // Ignored mid-packet frame_start; FCNT increments to 1
        px[0] = 12'h001; px[1] = 12'hFFF; px[2] = 12'h800; px[3] = 12'h7FE;
        base = got_a.size();
        expect_frame(0, PIX);
        pulse_start(0);
        drive_pixel(0, px[0], 1'b0);
        drive_pixel(0, px[1], 1'b0);
        pulse_start(0);
        drive_pixel(0, px[2], 1'b0);
        drive_pixel(0, px[3], 1'b0);
        wait_done(0, "midstart");
        check("fcnt_second", got_a[base + 2], 8'h01);

        // Short input: payload stalls after the first group while the window is open
        px[0] = 12'h0AB; px[1] = 12'h0CD; px[2] = 12'h0EF; px[3] = 12'h012;
        base = got_a.size();
        expect_frame(0, PIX);
        pulse_start(0);
        drive_pixel(0, px[0], 1'b0);
        drive_pixel(0, px[1], 1'b0);
        repeat (30) tick();
        check("short_bytes", got_a.size() - base, 6);
        check("short_valid", out_valid_a, 1'b0);
        check("short_busy", busy_a, 1'b1);
        drive_pixel(0, px[2], 1'b0);
        drive_pixel(0, px[3], 1'b0);
        wait_done(0, "short");

        // Overrange on the third pixel under random back-pressure
        px[0] = 12'h5A5; px[1] = 12'hA5A; px[2] = 12'hFFF; px[3] = 12'h000;
        ofs[2] = 1'b1;
        base = got_a.size();
        rand_mode = 1'b1;
        full_frame(0, "overrange");
        rand_mode = 1'b0;
        out_ready_a = 1'b1;
        ofs[2] = 1'b0;
        check("stat_of", got_a[base + NB - 2], 8'h40);

        // Overflow on the two-entry instance with the output held off
        px[0] = 12'h111; px[1] = 12'h222; px[2] = 12'h333; px[3] = 12'h444;
        expect_frame(1, PIX);
        pulse_start(1);
        for (int i = 0; i < PIX; i++) drive_pixel(1, px[i], 1'b0);
        tick();
        out_ready_b = 1'b1;
        wait_done(1, "overflow");
        check("ovf_sticky", overflow_b, 1'b1);
        for (int i = 0; i < NB; i++) check("ovf_literal", got_b[i], lit_ovf[i]);

        // Frame counter wrap
        for (int f = 0; f < 252; f++) begin
            for (int i = 0; i < PIX; i++) px[i] = 12'(f * 7 + i * 301);
            full_frame(0, "wrap_run");
        end
        base = got_a.size();
        full_frame(0, "wrap");
        check("fcnt_ff", got_a[base - NB + 2], 8'hFF);
        check("fcnt_wrap", got_a[base + 2], 8'h00);

        // Reset while presenting the PAY1 byte
        px[0] = 12'h321; px[1] = 12'h654; px[2] = 12'h987; px[3] = 12'hCBA;
        base = got_a.size();
        out_ready_a = 1'b0;
        expect_frame(0, PIX);
        pulse_start(0);
        for (int i = 0; i < PIX; i++) drive_pixel(0, px[i], 1'b0);
        out_ready_a = 1'b1;
        for (int n = 0; n < 100 && got_a.size() < base + 4; n++) tick();
        out_ready_a = 1'b0;
        check("pay1_reached", got_a.size() - base, 4);
        check("pay1_valid", out_valid_a, 1'b1);
        #3;
        rst_n = 1'b0;
        #1;
        check("arst_valid", out_valid_a, 1'b0);
        check("arst_data", out_data_a, 8'h00);
        check("arst_busy", busy_a, 1'b0);
        check("arst_overflow_b", overflow_b, 1'b0);
        exp_a.delete();
        fcnt_a = 8'h00;
        fcnt_b = 8'h00;
        tick();
        rst_n = 1'b1;
        out_ready_a = 1'b1;
        tick();
        base = got_a.size();
        full_frame(0, "post_reset");
        check("fcnt_after_reset", got_a[base + 2], 8'h00);

        repeat (5) tick();
        check("leftover_a", exp_a.size(), 0);
        check("leftover_b", exp_b.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
